// File: rtl/tictactoe_pkg.sv
// Shared cell, result and state encodings for the N x N tic-tac-toe controller.
// C_SEARCH exists only when TICTACTOE_AUTO_CPU_EN is defined.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY  = 2'b00,
        CELL_PLAYER = 2'b01,
        CELL_CPU    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        WHO_NONE   = 2'b00,
        WHO_PLAYER = 2'b01,
        WHO_CPU    = 2'b10,
        WHO_DRAW   = 2'b11
    } who_t;

    typedef enum logic [2:0] {
        P_WAIT,
        SCAN_P,
        C_WAIT,
        SCAN_C,
`ifdef TICTACTOE_AUTO_CPU_EN
        C_SEARCH,
`endif
        OVER
    } state_t;

endpackage

// File: rtl/tictactoe_nxn_if.sv
// Move-entry / board-display bundle; master drives moves, slave is the controller.
interface tictactoe_nxn_if #(
    parameter int N = 3
);
    localparam int CELLS = N * N;
    localparam int POS_W = $clog2(CELLS);

    logic               play;
    logic               pc;
    logic [POS_W-1:0]   player_position;
    logic [POS_W-1:0]   computer_position;
    logic [2*CELLS-1:0] board;
    logic [1:0]         who;
    logic               illegal;
    logic               busy;
    logic               game_over;

    modport master (
        output play, pc, player_position, computer_position,
        input  board, who, illegal, busy, game_over
    );

    modport slave (
        input  play, pc, player_position, computer_position,
        output board, who, illegal, busy, game_over
    );

endinterface

// File: rtl/tictactoe_line_check.sv
// Combinational K-in-a-row test from one cell in four directions:
// right, down, down-right and down-left. Off-board cells never match.
module tictactoe_line_check
    import tictactoe_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3,
    localparam int CELLS = N * N,
    localparam int POS_W = $clog2(CELLS)
) (
    input  logic [2*CELLS-1:0] board,
    input  logic [POS_W-1:0]   idx,
    input  cell_t              mark,
    output logic               found
);

    function automatic cell_t cell_at(input logic [2*CELLS-1:0] b, input int r, input int c);
        if (r < 0 || r >= N || c < 0 || c >= N) return CELL_EMPTY;
        return cell_t'(b[2*(r*N + c) +: 2]);
    endfunction

    int   row;
    int   col;
    logic hit_r, hit_d, hit_dr, hit_dl;

    // NOTE: every variable gets a value before any conditional update, so no latch is inferred.
    always_comb begin
        row    = int'(idx) / N;
        col    = int'(idx) % N;
        hit_r  = 1'b1;
        hit_d  = 1'b1;
        hit_dr = 1'b1;
        hit_dl = 1'b1;
        for (int k = 0; k < K; k++) begin
            if (cell_at(board, row,     col + k) != mark) hit_r  = 1'b0;
            if (cell_at(board, row + k, col)     != mark) hit_d  = 1'b0;
            if (cell_at(board, row + k, col + k) != mark) hit_dr = 1'b0;
            if (cell_at(board, row + k, col - k) != mark) hit_dl = 1'b0;
        end
        found = hit_r | hit_d | hit_dr | hit_dl;
    end

endmodule

// File: rtl/tictactoe_nxn.sv
// N x N, K-in-a-row tic-tac-toe controller with a one-cell-per-cycle win/draw scan.
// Define TICTACTOE_AUTO_CPU_EN to let the block place computer moves itself.
module tictactoe_nxn
    import tictactoe_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3
) (
    input logic            clock,
    input logic            reset,
    tictactoe_nxn_if.slave bus
);

    localparam int CELLS = N * N;
    localparam int POS_W = $clog2(CELLS);
    localparam logic [POS_W-1:0] LAST = POS_W'(CELLS - 1);

    state_t             state;
    logic [2*CELLS-1:0] board_q;
    who_t               who_q;
    logic               illegal_q;
    logic               busy_q;
    logic               game_over_q;
    logic [POS_W-1:0]   idx;
    logic               win_acc;
    logic               empty_acc;

    logic  line_found;
    cell_t scan_mark;
    cell_t scan_cell;
    logic  win_now;
    logic  empty_now;
    logic  player_ok;

    // Positions past the last cell read as occupied, so one test covers range and vacancy.
    function automatic cell_t cell_of(input logic [2*CELLS-1:0] b, input logic [POS_W-1:0] pos);
        if (int'(pos) >= CELLS) return CELL_CPU;
        return cell_t'(b[2*int'(pos) +: 2]);
    endfunction

    assign scan_mark = (state == SCAN_C) ? CELL_CPU : CELL_PLAYER;
    assign scan_cell = cell_of(board_q, idx);
    assign win_now   = win_acc | line_found;
    assign empty_now = empty_acc | (scan_cell == CELL_EMPTY);
    assign player_ok = (cell_of(board_q, bus.player_position) == CELL_EMPTY);

`ifndef TICTACTOE_AUTO_CPU_EN
    logic cpu_ok;
    assign cpu_ok = (cell_of(board_q, bus.computer_position) == CELL_EMPTY);
`endif

    tictactoe_line_check #(
        .N (N),
        .K (K)
    ) u_line_check (
        .board (board_q),
        .idx   (idx),
        .mark  (scan_mark),
        .found (line_found)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= P_WAIT;
            // NOTE: the board is a small register array and is cleared on reset, since an empty board is the game's start state.
            board_q     <= '0;
            who_q       <= WHO_NONE;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
            idx         <= '0;
            win_acc     <= 1'b0;
            empty_acc   <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            unique case (state)
                P_WAIT: begin
                    if (bus.play) begin
                        if (player_ok) begin
                            board_q[2*int'(bus.player_position) +: 2] <= CELL_PLAYER;
                            state     <= SCAN_P;
                            busy_q    <= 1'b1;
                            idx       <= '0;
                            win_acc   <= 1'b0;
                            empty_acc <= 1'b0;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end

                C_WAIT: begin
`ifndef TICTACTOE_AUTO_CPU_EN
                    if (bus.pc) begin
                        if (cpu_ok) begin
                            board_q[2*int'(bus.computer_position) +: 2] <= CELL_CPU;
                            state     <= SCAN_C;
                            busy_q    <= 1'b1;
                            idx       <= '0;
                            win_acc   <= 1'b0;
                            empty_acc <= 1'b0;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
`endif
                end

                SCAN_P, SCAN_C: begin
                    if (idx == LAST) begin
                        idx <= '0;
                        if (win_now) begin
                            state       <= OVER;
                            busy_q      <= 1'b0;
                            who_q       <= (state == SCAN_C) ? WHO_CPU : WHO_PLAYER;
                            game_over_q <= 1'b1;
                        end else if (!empty_now) begin
                            state       <= OVER;
                            busy_q      <= 1'b0;
                            who_q       <= WHO_DRAW;
                            game_over_q <= 1'b1;
                        end else if (state == SCAN_C) begin
                            state  <= P_WAIT;
                            busy_q <= 1'b0;
                        end else begin
`ifdef TICTACTOE_AUTO_CPU_EN
                            state  <= C_SEARCH;
`else
                            state  <= C_WAIT;
                            busy_q <= 1'b0;
`endif
                        end
                    end else begin
                        idx       <= idx + POS_W'(1);
                        win_acc   <= win_now;
                        empty_acc <= empty_now;
                    end
                end

`ifdef TICTACTOE_AUTO_CPU_EN
                // The preceding scan saw an empty cell, so this walk always terminates.
                C_SEARCH: begin
                    if (scan_cell == CELL_EMPTY) begin
                        board_q[2*int'(idx) +: 2] <= CELL_CPU;
                        state     <= SCAN_C;
                        idx       <= '0;
                        win_acc   <= 1'b0;
                        empty_acc <= 1'b0;
                    end else begin
                        idx <= idx + POS_W'(1);
                    end
                end
`endif

                OVER: begin
                    state <= OVER;
                end

                default: begin
                    state <= P_WAIT;
                end
            endcase
        end
    end

    assign bus.board     = board_q;
    assign bus.who       = who_q;
    assign bus.illegal   = illegal_q;
    assign bus.busy      = busy_q;
    assign bus.game_over = game_over_q;

endmodule
